// File: rtl/sdram_pattern_tester.sv
// Memory pattern tester: writes a generated pattern across an address range, reads it back,
// counts mismatches, and supports looping, stop requests and a per-request ack timeout.
module sdram_pattern_tester #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 32,
  parameter int                ADDR_STEP = 1,
  parameter int                ERR_W     = 16,
  parameter int                PASS_W    = 16,
  parameter int                TIMEOUT   = 1023,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1),
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  output logic              writeport_wr,
  output logic [ADDR_W-1:0] writeport_addr,
  output logic [DATA_W-1:0] writeport_data,
  input  logic              writeport_ack,
  output logic              readport_rd,
  output logic [ADDR_W-1:0] readport_addr,
  input  logic [DATA_W-1:0] readport_data,
  input  logic              readport_ack,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              timeout,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [DATA_W-1:0] gen_word(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic [IDX_W-1:0]  idx,
    input logic              odd_word,
    input logic [DATA_W-1:0] lfsr,
    input logic              odd_pass
  );
    logic [DATA_W-1:0] w;
    w = '0;
    case (m)
      2'd0:    w = DATA_W'(a);
      2'd1:    w = DATA_W'(1) << idx;
      2'd2:    w = lfsr;
      default: for (int b = 0; b < DATA_W; b++) w[b] = ((b % 2) == 0) ^ odd_word ^ odd_pass;
    endcase
    return w;
  endfunction

  state_t            state_q;
  logic              wr_q, rd_q;
  logic [ADDR_W-1:0] port_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q, done_q, cfg_err_q, timeout_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [DATA_W-1:0] first_err_data_q;
  logic              captured_q, stop_seen_q;
  logic [ADDR_W-1:0] lo_q, hi_q, addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              par_q;
  logic [DATA_W-1:0] lfsr_q, rdata_q;
  logic [TO_W-1:0]   wait_q;
  logic [1:0]        mode_q;

  logic [DATA_W-1:0] exp_word, lfsr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [IDX_W-1:0]  idx_d;
  logic              last_word, stop_any;

  assign exp_word  = gen_word(mode_q, addr_q, idx_q, par_q, lfsr_q, pass_cnt_q[0]);
  assign addr_d    = addr_q + STEP;
  assign idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign lfsr_d    = lfsr_next(lfsr_q);
  // Distance test instead of addr+STEP > hi, so a range ending near the top never wraps.
  assign last_word = (hi_q - addr_q) < STEP;
  assign stop_any  = stop_seen_q | stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      wr_q             <= 1'b0;
      rd_q             <= 1'b0;
      port_addr_q      <= '0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      cfg_err_q        <= 1'b0;
      timeout_q        <= 1'b0;
      pass_cnt_q       <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      captured_q       <= 1'b0;
      stop_seen_q      <= 1'b0;
      lo_q             <= '0;
      hi_q             <= '0;
      addr_q           <= '0;
      idx_q            <= '0;
      par_q            <= 1'b0;
      lfsr_q           <= '0;
      rdata_q          <= '0;
      wait_q           <= '0;
      mode_q           <= 2'd0;
    end else begin
      if (busy_q && stop) stop_seen_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            lo_q             <= addr_lo;
            hi_q             <= addr_hi;
            mode_q           <= mode;
            pass_cnt_q       <= '0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            captured_q       <= 1'b0;
            stop_seen_q      <= 1'b0;
            timeout_q        <= 1'b0;
            addr_q           <= addr_lo;
            idx_q            <= '0;
            par_q            <= 1'b0;
            lfsr_q           <= LFSR_SEED;
            wait_q           <= '0;
            if (addr_lo > addr_hi) begin
              cfg_err_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              cfg_err_q   <= 1'b0;
              done_q      <= 1'b0;
              busy_q      <= 1'b1;
              wr_q        <= 1'b1;
              port_addr_q <= addr_lo;
              wdata_q     <= gen_word(mode, addr_lo, '0, 1'b0, LFSR_SEED, 1'b0);
              state_q     <= S_WR_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (wr_q) begin
            if (writeport_ack) begin
              wr_q   <= 1'b0;
              wait_q <= '0;
              if (last_word) begin
                addr_q <= lo_q;
                idx_q  <= '0;
                par_q  <= 1'b0;
                lfsr_q <= LFSR_SEED;
              end else begin
                addr_q <= addr_d;
                idx_q  <= idx_d;
                par_q  <= ~par_q;
                lfsr_q <= lfsr_d;
              end
              if (stop_any) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else if (last_word) begin
                state_q <= S_RD_REQ;
              end
            end else if (wait_q == TO_LAST) begin
              wr_q      <= 1'b0;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end else if (stop_any) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wr_q        <= 1'b1;
            port_addr_q <= addr_q;
            wdata_q     <= exp_word;
          end
        end
        S_RD_REQ: begin
          if (rd_q) begin
            if (readport_ack) begin
              rd_q    <= 1'b0;
              wait_q  <= '0;
              rdata_q <= readport_data;
              state_q <= S_CHECK;
            end else if (wait_q == TO_LAST) begin
              rd_q      <= 1'b0;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end else if (stop_any) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rd_q        <= 1'b1;
            port_addr_q <= addr_q;
          end
        end
        S_CHECK: begin
          if (rdata_q != exp_word) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (!captured_q) begin
              captured_q       <= 1'b1;
              first_err_addr_q <= addr_q;
              first_err_data_q <= rdata_q;
            end
          end
          if (last_word) begin
            pass_cnt_q <= pass_cnt_q + 1'b1;
            addr_q     <= lo_q;
            idx_q      <= '0;
            par_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            if (loop && !stop_any) begin
              state_q <= S_WR_REQ;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
            par_q  <= ~par_q;
            lfsr_q <= lfsr_d;
            if (stop_any) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RD_REQ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign writeport_wr   = wr_q;
  assign writeport_addr = port_addr_q;
  assign writeport_data = wdata_q;
  assign readport_rd    = rd_q;
  assign readport_addr  = port_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;
  assign timeout        = timeout_q;
  assign pass_cnt       = pass_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 SHALL have parameters: DATA_W (default 16, data width); ADDR_W (default 32, address width); ADDR_STEP (default 1, address increment per word); ERR_W (default 16, error counter width); PASS_W (default 16, pass counter width); TIMEOUT (default 1023, max cycles waiting for an ack); LFSR_SEED (default 1, nonzero LFSR seed); LFSR_TAPS (default 16'hB400, Galois feedback mask).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock; all logic on rising edge
 rst_n  in  1  reset; asynchronous assert, active-low
 start  in  1  begin test; sampled in IDLE only
 stop  in  1  request end after current transaction
 mode  in  2  pattern: 0 addr, 1 walking-one, 2 LFSR, 3 checkerboard
 loop  in  1  repeat passes until stop
 addr_lo, addr_hi  in  ADDR_W  inclusive test range
 writeport_wr  out  1  write request
 writeport_addr  out  ADDR_W  write address
 writeport_data  out  DATA_W  write data
 writeport_ack  in  1  write accepted
 readport_rd  out  1  read request
 readport_addr  out  ADDR_W  read address
 readport_data  in  DATA_W  read data, valid with ack
 readport_ack  in  1  read data valid
 busy, done  out  1  running / finished (done held until next start)
 cfg_err, timeout  out  1  bad range / missing ack
 pass_cnt  out  PASS_W  completed passes
 err_cnt  out  ERR_W  mismatches, saturating
 first_err_addr  out  ADDR_W  address of first mismatch
 first_err_data  out  DATA_W  data read at first mismatch

Function
REQ-003 SHALL implement FSM IDLE -> WR_REQ -> RD_REQ -> CHECK -> DONE; WR_REQ loops per word, RD_REQ/CHECK loop per word.
REQ-004 SHALL, on start=1 in IDLE with addr_lo<=addr_hi: clear counters, error capture, done, cfg_err, timeout; assert busy and writeport_wr the next cycle at addr_lo.
REQ-005 SHALL, on start with addr_lo>addr_hi: go to DONE next cycle with cfg_err=1, no port requests.
REQ-006 SHALL hold each request high with address/data stable until ack is sampled high, deassert it the cycle after ack, and keep at most one request outstanding; writeport_wr and readport_rd never high together.
REQ-007 SHALL advance address by ADDR_STEP after each ack; phase ends on the ack at address equal to addr_hi, or when the next address would exceed addr_hi (comparison made before increment, so no ADDR_W wrap-around).
REQ-008 SHALL generate data per word index i (0 at addr_lo): mode 0 address[DATA_W-1:0]; mode 1 1<<(i mod DATA_W); mode 2 Galois LFSR reseeded to LFSR_SEED at start of each write and read phase, advanced once per word; mode 3 alternating 0x55../0xAA.. by i, inverted on odd pass_cnt.
REQ-009 SHALL register readport_data on readport_ack and compare against the regenerated expected word in CHECK (one cycle); on mismatch increment err_cnt (saturate at all-ones), and capture first_err_addr/data only on the first mismatch since start.
REQ-010 SHALL at end of read phase increment pass_cnt (wrapping); if loop=1 and stop not seen, restart write phase at addr_lo; else DONE.
REQ-011 SHALL latch stop while busy; transaction in flight completes, then DONE without further requests.
REQ-012 SHALL count cycles a request waits; at TIMEOUT cycles without ack, drop the request, set timeout=1, enter DONE.
REQ-013 SHALL in DONE drive busy=0, done=1 and return to IDLE; start while busy is ignored.

Reset
REQ-014 SHALL on rst_n=0 immediately force IDLE and all outputs to 0 (requests, busy, done, flags, counters, capture registers), including mid-transaction.
REQ-015 SHALL resume operation only on a start after rst_n deasserts.

Verification
REQ-016 mode 0, range 0..7, ack 2 cycles after request, no loop -> 8 writes data 0..7, 8 reads, pass_cnt=1, err_cnt=0, done=1.
REQ-017 mode 2, read at address 3 returns corrupted data 0xDEAD -> err_cnt=1, first_err_addr=3, first_err_data=0xDEAD.
REQ-018 addr_lo=5, addr_hi=4 -> cfg_err=1, done=1 within 2 cycles, no writeport_wr.
REQ-019 writeport_ack held low -> timeout=1 after TIMEOUT cycles, writeport_wr drops, done=1.
REQ-020 loop=1 with stop pulsed during pass 3 -> current transaction completes, done=1, pass_cnt=2; rst_n pulse mid-write -> writeport_wr=0 immediately, all counters 0.
